// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP multiply-accumulate controller:
// controller state encoding and the DSP opmode constants.
package dsp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2
   } mac_state_t;

   // P = A*B (clear) and P = P + A*B (accumulate)
   localparam logic [7:0] OPM_MUL_CLR = 8'h01;
   localparam logic [7:0] OPM_MUL_ACC = 8'h09;

endpackage

// File: rtl/dsp_valid_pipe.sv
// Delay line that shadows the DSP datapath: carries the "beat accepted"
// strobe and the "first beat of the command" flag alongside the operands.
// o_vld[k-1] is the valid at stage k. The first flag is only needed up
// to stage DEPTH-1, where it selects the opmode for the P load.
module dsp_valid_pipe #(
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_vld,
   input  logic             i_first,
   output logic [DEPTH-1:0] o_vld,
   output logic             o_first_p
);

   logic [DEPTH-1:0] r_vld;
   logic [DEPTH-2:0] r_first;

   // Shift valid/first one stage per clock; a synchronous clear drops every beat in flight.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         r_vld   <= '0;
         r_first <= '0;
      end else if (i_clr) begin
         r_vld   <= '0;
         r_first <= '0;
      end else begin
         r_vld[0]   <= i_vld;
         r_first[0] <= i_first;
         for (int k = 1; k < DEPTH; k++) begin
            r_vld[k] <= r_vld[k-1];
         end
         for (int k = 1; k < DEPTH - 1; k++) begin
            r_first[k] <= r_first[k-1];
         end
      end
   end

   assign o_vld     = r_vld;
   assign o_first_p = r_first[DEPTH-2];

endmodule

// File: rtl/dsp_mac_ctrl.sv
// Command controller for a DSP48-style multiply-accumulate slice.
// Accepts len operand pairs, steers the slice clock enables so bubbles
// freeze the datapath, clears the accumulator on the first beat, and
// captures P once the last beat has landed.
module dsp_mac_ctrl #(
   parameter int WIDTH    = 18,
   parameter int PIPE_LAT = 4,
   parameter int LEN_W    = 8
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] dsp_a,
   output logic [WIDTH-1:0] dsp_b,
   output logic             cea,
   output logic             ceb,
   output logic             cem,
   output logic             cep,
   output logic [7:0]       opmode,
   input  logic [47:0]      p_in,
   output logic [47:0]      result,
   output logic             done,
   output logic             busy
);
   import dsp_pkg::*;

   mac_state_t       r_state, w_state_nxt;
   logic [LEN_W-1:0] r_beats_left;
   logic             r_first_pend;
   logic [47:0]      r_result;
   logic             r_done;

   logic             w_launch;    // IDLE + start with a non-empty command
   logic             w_zero_cmd;  // IDLE + start with len == 0
   logic             w_accept;    // beat taken into the datapath
   logic             w_kill;      // abort of an active command
   logic             w_capture;   // last beat has reached P
   logic             w_drained;
   logic [PIPE_LAT-1:0] w_vld;
   logic             w_first_p;

   // Final beat sits alone in the last stage: P already holds the full sum.
   assign w_drained = w_vld[PIPE_LAT-1] && (w_vld[PIPE_LAT-2:0] == '0);

   // State register.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state and per-cycle control strobes; abort outranks a same-cycle beat.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      w_launch    = 1'b0;
      w_zero_cmd  = 1'b0;
      w_accept    = 1'b0;
      w_kill      = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (len != '0) begin
                  w_launch    = 1'b1;
                  w_state_nxt = ST_LOAD;
               end else begin
                  w_zero_cmd  = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            in_ready = 1'b1;
            if (abort) begin
               w_kill      = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (in_valid) begin
               w_accept = 1'b1;
               if (r_beats_left == LEN_W'(1)) w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (abort) begin
               w_kill      = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (w_drained) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Beat counter and first-beat marker for the command in progress.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         r_beats_left <= '0;
         r_first_pend <= 1'b0;
      end else if (w_kill) begin
         r_beats_left <= '0;
         r_first_pend <= 1'b0;
      end else if (w_launch) begin
         r_beats_left <= len;
         r_first_pend <= 1'b1;
      end else if (w_accept) begin
         r_beats_left <= r_beats_left - LEN_W'(1);
         r_first_pend <= 1'b0;
      end
   end

   // Result capture and the one-cycle completion pulse.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         r_result <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= w_capture | w_zero_cmd;
         if (w_zero_cmd)     r_result <= '0;
         else if (w_capture) r_result <= p_in;
      end
   end

   // Stage 0: operand capture into the slice A/B registers
   assign dsp_a = a_in;
   assign dsp_b = b_in;
   assign cea   = w_accept;
   assign ceb   = w_accept;

   dsp_valid_pipe #(
      .DEPTH (PIPE_LAT)
   ) u_vpipe (
      .CLK       (CLK),
      .rst       (rst),
      .i_clr     (w_kill),
      .i_vld     (w_accept),
      .i_first   (w_accept & r_first_pend),
      .o_vld     (w_vld),
      .o_first_p (w_first_p)
   );

   // Stage 1: multiplier register
   assign cem = w_vld[0];

   // Stage PIPE_LAT-1: P register load, opmode aligned to this beat
   assign cep    = w_vld[PIPE_LAT-2];
   assign opmode = (cep && !w_first_p) ? OPM_MUL_ACC : OPM_MUL_CLR;

   assign result = r_result;
   assign done   = r_done;
   assign busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dsp_mac_ctrl.sv
// Directed bench for dsp_mac_ctrl with a small behavioural DSP slice
// (A/B, M, one internal delay, P) giving a 4-cycle operand-to-P latency.
module tb_dsp_mac_ctrl;
   localparam int WIDTH    = 18;
   localparam int PIPE_LAT = 4;
   localparam int LEN_W    = 8;
   localparam logic [7:0] CLR = 8'h01;
   localparam logic [7:0] ACC = 8'h09;

   logic             CLK = 1'b0;
   logic             rst, start, abort, in_valid;
   logic [LEN_W-1:0] len;
   logic [WIDTH-1:0] a_in, b_in, dsp_a, dsp_b;
   logic             in_ready, cea, ceb, cem, cep, done, busy;
   logic [7:0]       opmode;
   logic [47:0]      p_in, result;

   int total = 0;
   int bad   = 0;

   dsp_mac_ctrl #(
      .WIDTH    (WIDTH),
      .PIPE_LAT (PIPE_LAT),
      .LEN_W    (LEN_W)
   ) dut (
      .CLK      (CLK),
      .rst      (rst),
      .start    (start),
      .len      (len),
      .abort    (abort),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a_in     (a_in),
      .b_in     (b_in),
      .dsp_a    (dsp_a),
      .dsp_b    (dsp_b),
      .cea      (cea),
      .ceb      (ceb),
      .cem      (cem),
      .cep      (cep),
      .opmode   (opmode),
      .p_in     (p_in),
      .result   (result),
      .done     (done),
      .busy     (busy)
   );

   always #5 CLK = ~CLK;

   // Behavioural DSP slice
   logic [WIDTH-1:0]   m_a = '0, m_b = '0;
   logic [2*WIDTH-1:0] m_m = '0, m_d = '0;
   logic [47:0]        m_p = '0;

   always @(posedge CLK) begin
      if (cea) m_a <= dsp_a;
      if (ceb) m_b <= dsp_b;
      if (cem) m_m <= m_a * m_b;
      m_d <= m_m;
      if (cep) m_p <= (opmode == CLR) ? 48'(m_d) : m_p + 48'(m_d);
   end
   assign p_in = m_p;

   task automatic chkb(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk48(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge CLK);
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      in_valid = v;
      a_in     = a;
      b_in     = b;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0;
      drive(1'b0, '0, '0);

      // reset state
      step(); step(); #1;
      chkb("rst_busy", busy, 1'b0);
      chkb("rst_done", done, 1'b0);
      chkb("rst_ready", in_ready, 1'b0);
      chkb("rst_cea", cea, 1'b0);
      chkb("rst_cem", cem, 1'b0);
      chkb("rst_cep", cep, 1'b0);
      chk8("rst_opmode", opmode, CLR);
      chk48("rst_result", result, 48'd0);
      step(); rst = 1'b0;

      // three back-to-back beats: 2*3 + 4*5 + 1*7 = 33
      step(); start = 1'b1; len = 8'd3; #1;
      chkb("t1_idle_busy", busy, 1'b0);
      chkb("t1_idle_ready", in_ready, 1'b0);
      step(); start = 1'b0; drive(1'b1, 18'd2, 18'd3); #1;
      chkb("t1_busy", busy, 1'b1);
      chkb("t1_ready", in_ready, 1'b1);
      chkb("t1_cea", cea, 1'b1);
      chk48("t1_dsp_a", 48'(dsp_a), 48'd2);
      step(); drive(1'b1, 18'd4, 18'd5); #1;
      chkb("t1_cem", cem, 1'b1);
      step(); drive(1'b1, 18'd1, 18'd7); #1;
      chkb("t1_ceb", ceb, 1'b1);
      for (int i = 1; i <= 5; i++) begin
         step(); drive(1'b0, '0, '0); #1;
         chkb("t1_done_lat", done, i == 5);
         if (i == 1) begin
            chkb("t1_drain_ready", in_ready, 1'b0);
            chkb("t1_cep_b0", cep, 1'b1);
            chk8("t1_opm_b0", opmode, CLR);
         end
         if (i == 2) chk8("t1_opm_b1", opmode, ACC);
         if (i == 3) chk8("t1_opm_b2", opmode, ACC);
         if (i == 4) chkb("t1_cep_off", cep, 1'b0);
      end
      chk48("t1_result", result, 48'd33);
      step(); #1;
      chkb("t1_done_off", done, 1'b0);
      chkb("t1_idle_again", busy, 1'b0);

      // zero-length command
      step(); start = 1'b1; len = 8'd0; #1;
      chkb("t3_busy0", busy, 1'b0);
      step(); start = 1'b0; #1;
      chkb("t3_done", done, 1'b1);
      chk48("t3_result", result, 48'd0);
      chkb("t3_busy1", busy, 1'b0);
      step(); #1;
      chkb("t3_done_off", done, 1'b0);

      // two beats with a 3-cycle gap: 11*13 + 200000*150000 = 30000000143
      step(); start = 1'b1; len = 8'd2; #1;
      step(); start = 1'b0; drive(1'b1, 18'd11, 18'd13); #1;
      chkb("t2_cea0", cea, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(); drive(1'b0, '0, '0); #1;
         chkb("t2_gap_cea", cea, 1'b0);
         chkb("t2_gap_ready", in_ready, 1'b1);
         chkb("t2_cep_first", cep, i == 2);
      end
      step(); drive(1'b1, 18'd200000, 18'd150000); #1;
      chkb("t2_cea1", cea, 1'b1);
      chkb("t2_gap_cep5", cep, 1'b0);
      step(); drive(1'b0, '0, '0); #1;
      chkb("t2_gap_cep6", cep, 1'b0);
      chkb("t2_drain_ready", in_ready, 1'b0);
      step(); #1;
      chkb("t2_gap_cep7", cep, 1'b0);
      step(); #1;
      chkb("t2_cep1", cep, 1'b1);
      chk8("t2_opm1", opmode, ACC);
      step(); #1;
      chkb("t2_done_early", done, 1'b0);
      step(); #1;
      chkb("t2_done", done, 1'b1);
      chk48("t2_result", result, 48'd30000000143);

      // abort after one of four beats (abort coincides with a valid beat)
      step(); start = 1'b1; len = 8'd4; #1;
      step(); start = 1'b0; drive(1'b1, 18'd5, 18'd6); #1;
      chkb("t4_cea", cea, 1'b1);
      step(); drive(1'b1, 18'd8, 18'd8); abort = 1'b1; #1;
      chkb("t4_busy_abort", busy, 1'b1);
      step(); abort = 1'b0; drive(1'b0, '0, '0); #1;
      chkb("t4_idle", busy, 1'b0);
      chkb("t4_ready", in_ready, 1'b0);
      chkb("t4_cem_clr", cem, 1'b0);
      step(); #1;
      chkb("t4_cep_clr", cep, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step(); #1;
         chkb("t4_no_done", done, 1'b0);
      end
      chk48("t4_result_kept", result, 48'd30000000143);

      // start pulsed during LOAD is ignored: 3*4 + 6*2 = 24
      step(); start = 1'b1; len = 8'd2; #1;
      step(); start = 1'b1; len = 8'd5; drive(1'b1, 18'd3, 18'd4); #1;
      chkb("t5_busy", busy, 1'b1);
      step(); start = 1'b0; len = 8'd0; drive(1'b1, 18'd6, 18'd2); #1;
      chkb("t5_ready", in_ready, 1'b1);
      step(); drive(1'b0, '0, '0); #1;
      chkb("t5_drain_ready", in_ready, 1'b0);
      chkb("t5_drain_busy", busy, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(); #1;
         chkb("t5_done_early", done, 1'b0);
      end
      step(); #1;
      chkb("t5_done", done, 1'b1);
      chk48("t5_result", result, 48'd24);

      // asynchronous reset in DRAIN
      step(); start = 1'b1; len = 8'd2; #1;
      step(); start = 1'b0; drive(1'b1, 18'd9, 18'd9); #1;
      step(); drive(1'b1, 18'd2, 18'd2); #1;
      step(); drive(1'b0, '0, '0); #1;
      step(); #1;
      step(); #1;
      chkb("t6_pre_cep", cep, 1'b1);
      chk8("t6_pre_opm", opmode, ACC);
      chkb("t6_pre_busy", busy, 1'b1);
      #1 rst = 1'b1;
      #1;
      chkb("t6_busy", busy, 1'b0);
      chkb("t6_cep", cep, 1'b0);
      chkb("t6_cem", cem, 1'b0);
      chkb("t6_cea", cea, 1'b0);
      chkb("t6_ready", in_ready, 1'b0);
      chkb("t6_done", done, 1'b0);
      chk8("t6_opm", opmode, CLR);
      chk48("t6_result", result, 48'd0);
      step(); rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(); #1;
         chkb("t6_no_done", done, 1'b0);
         chkb("t6_stay_idle", busy, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
